ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative signed 16-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline buffer. It consumes the forwarded operands, destination register and control from the buffer outputs. It holds the pipeline via `busy` while it iterates, then delivers a 32-bit result: the low half goes to the destination register and the high half to R15. Multiply yields the {high, low} product; divide yields {remainder, quotient}.

## Interface
- No parameters; the datapath is fixed at 16 bits and the iteration count at 16.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request from the ID/EX outputs that the current instruction is mul/div.
- `op` in 1: 0 = multiply, 1 = divide; sampled with `start`.
- `flush` in 1: kills any in-flight operation.
- `op1` in 16: forwarded operand 1 (multiplicand / dividend), two's complement.
- `op2` in 16: forwarded operand 2 (multiplier / divisor), two's complement.
- `regDes_IN` in 4: destination register of the instruction.
- `busy` out 1: stall request to the hazard unit.
- `done` out 1: one-cycle result-valid pulse.
- `result_lo` out 16: product[15:0] or quotient.
- `result_hi` out 16: product[31:16] or remainder; written to R15.
- `regDes_OUT` out 4: captured destination register.
- `regWriteOUT` out 1: equals `done`.
- `R15WriteOUT` out 1: equals `done`.
- `div_by_zero` out 1: sticky flag; set when a divide with op2 = 0 completes, cleared on the next accepted `start`.

## Operation
- **States:** IDLE, RUN, FIX, DONE. All state is registered.
- **Accept:** `start` is accepted in IDLE or DONE when `flush` = 0. `start` in RUN or FIX is ignored.
- **On accept, the unit captures:**
  - `op` and `regDes_IN`;
  - the magnitudes |op1| and |op2|;
  - sign_lo = op1[15] ^ op2[15];
  - sign_hi = op1[15] for divide, and sign_lo for multiply.
- **Accept transitions:** the iteration counter is cleared to 0 and the next state is RUN. The exception is a divide with op2 = 0, which goes directly to DONE.
- **RUN:** one iteration per cycle, counter 0..15. After iteration 15 the next state is FIX.
  - Multiply is shift-add on the 32-bit unsigned magnitude product.
  - Divide is restoring division: 16-bit quotient and 16-bit remainder on magnitudes.
- **FIX:** sign correction.
  - Multiply: negate the 32-bit product if sign_lo is set.
  - Divide: negate the quotient if sign_lo is set; negate the remainder if sign_hi is set.
  - The corrected values are loaded into `result_lo` / `result_hi`, and the next state is DONE.
- **DONE:** `done` = 1 for exactly one cycle. Next state is RUN if a new `start` is accepted, otherwise IDLE.
- **Divide by zero:** `result_lo` = 16'hFFFF, `result_hi` = op1 (unmodified), `div_by_zero` = 1.
- **Overflow rules:**
  - -32768 / -1 gives quotient 16'h8000 and remainder 0, with no flag.
  - -32768 × -32768 gives 32'h4000_0000, which is exact.
- **Flush:**
  - In RUN or FIX, `flush` forces IDLE on the next edge. No `done` is produced, and `result_*` and `regDes_OUT` keep their prior values.
  - In DONE, `flush` is ignored; the result still commits.
  - In IDLE/DONE, `flush` together with `start` means `start` is not accepted.
- **Output hold:** `result_*`, `regDes_OUT` and `div_by_zero` hold their values until the next accept or FIX update.
- **Busy:** `busy` = 1 exactly in RUN and FIX.

## Timing
- Reset (`rst` = 0, asynchronous) sets the state to IDLE and all outputs to 0: `busy`, `done`, `result_lo`, `result_hi`, `regDes_OUT`, `regWriteOUT`, `R15WriteOUT` and `div_by_zero`. This applies from any state, including mid-RUN.
- Start sampled at edge N (normal case):
  - `busy` = 1 in cycles N+1 .. N+17 (16 RUN cycles and 1 FIX cycle);
  - `done` = 1 in cycle N+18;
  - results are valid from cycle N+18.
- Divide by zero: `done` = 1 in cycle N+1 and `busy` is never asserted.
- The hazard unit owns the stall during the `start` cycle itself. `busy` is registered and first rises in cycle N+1.
- Back-to-back: a `start` accepted in the DONE cycle M gives the next `done` at M+18.

## Test plan
- **Reset mid-RUN:** assert `rst` = 0 at RUN iteration 7 -> immediately `busy` = 0, `done` = 0, all outputs 0. After release, a new op completes normally.
- **Multiply:** op1 = 16'h0003, op2 = 16'hFFFE, regDes_IN = 4'h5 at edge N -> `busy` high N+1..N+17; at N+18 `done` = 1, `result_lo` = 16'hFFFA, `result_hi` = 16'hFFFF, `regDes_OUT` = 4'h5, `R15WriteOUT` = 1.
- **Divide:** 16'h0007 / 16'h0002 -> quotient 16'h0003, remainder 16'h0001. Then 16'hFFF9 / 16'h0002 -> quotient 16'hFFFD, remainder 16'hFFFF. Then 16'h8000 / 16'hFFFF -> quotient 16'h8000, remainder 16'h0000.
- **Divide by zero:** 16'h1234 / 16'h0000 -> `done` at N+1, `result_lo` = 16'hFFFF, `result_hi` = 16'h1234, `div_by_zero` = 1, `busy` never high. The next accepted `start` clears `div_by_zero`.
- **Flush:** pulse `flush` at RUN iteration 5 -> IDLE next cycle, no `done`, results keep the previous operation's values. Flush in the DONE cycle -> `done` still 1.
- **Back-to-back:** `start` (multiply 16'h0100 × 16'h0100) in the DONE cycle of the previous op -> accepted, `result_hi` = 16'h0001, `result_lo` = 16'h0000, 18 cycles later. A `start` pulsed during RUN is ignored.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and data bundle between the ID/EX buffer and the iterative
// multiply/divide unit in the EX stage.
interface ex_muldiv_unit_if;
    logic        start;
    logic        op;
    logic        flush;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  regDes_IN;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [3:0]  regDes_OUT;
    logic        regWriteOUT;
    logic        R15WriteOUT;
    logic        div_by_zero;

    modport master (
        output start, op, flush, op1, op2, regDes_IN,
        input  busy, done, result_lo, result_hi, regDes_OUT,
               regWriteOUT, R15WriteOUT, div_by_zero
    );

    modport slave (
        input  start, op, flush, op1, op2, regDes_IN,
        output busy, done, result_lo, result_hi, regDes_OUT,
               regWriteOUT, R15WriteOUT, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative signed 16x16 multiply (shift-add) and 16/16 divide (restoring)
// operating on magnitudes, with a final sign-correction cycle.
module ex_muldiv_unit (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [15:0] neg16(input logic [15:0] v);
        return 16'h0000 - v;
    endfunction

    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? neg16(v) : v;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic        div0_s;
    logic        busy_r;
    logic        done_r;
    logic [3:0]  cnt_r;
    logic        op_r;
    logic        sign_lo_r;
    logic        sign_hi_r;
    logic [3:0]  des_r;
    logic [15:0] acc_hi_r;
    logic [15:0] acc_lo_r;
    logic [15:0] mag_b_r;
    logic [15:0] result_lo_r;
    logic [15:0] result_hi_r;
    logic [3:0]  regdes_out_r;
    logic        div_by_zero_r;
    logic [15:0] mag_a_s;
    logic [15:0] mag_b_s;
    logic [16:0] mul_sum_s;
    logic [16:0] div_shift_s;
    logic [16:0] div_trial_s;
    logic [31:0] fix_prod_s;

    // Next-state decode and start acceptance
    always_comb begin
        accept_s     = 1'b0;
        div0_s       = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start && !bus.flush) begin
                    accept_s = 1'b1;
                    if (bus.op && (bus.op2 == 16'h0000)) begin
                        div0_s       = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == 4'd15) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (bus.flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-iteration arithmetic and sign-corrected product
    always_comb begin
        mag_a_s     = abs16(bus.op1);
        mag_b_s     = abs16(bus.op2);
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mag_b_r} : 17'd0);
        div_shift_s = {acc_hi_r, acc_lo_r[15]};
        div_trial_s = div_shift_s - {1'b0, mag_b_r};
        fix_prod_s  = sign_lo_r ? (32'd0 - {acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
    end

    // State register with registered busy/done decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_FIX);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, iteration and result registers; acc_lo holds the
    // multiplier (mul) or the dividend shifting into the quotient (div).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r         <= 4'd0;
            op_r          <= 1'b0;
            sign_lo_r     <= 1'b0;
            sign_hi_r     <= 1'b0;
            des_r         <= 4'd0;
            acc_hi_r      <= 16'h0000;
            acc_lo_r      <= 16'h0000;
            mag_b_r       <= 16'h0000;
            result_lo_r   <= 16'h0000;
            result_hi_r   <= 16'h0000;
            regdes_out_r  <= 4'd0;
            div_by_zero_r <= 1'b0;
        end else if (accept_s) begin
            op_r          <= bus.op;
            des_r         <= bus.regDes_IN;
            sign_lo_r     <= bus.op1[15] ^ bus.op2[15];
            sign_hi_r     <= bus.op ? bus.op1[15] : (bus.op1[15] ^ bus.op2[15]);
            cnt_r         <= 4'd0;
            acc_hi_r      <= 16'h0000;
            div_by_zero_r <= div0_s;
            if (bus.op) begin
                acc_lo_r <= mag_a_s;
                mag_b_r  <= mag_b_s;
            end else begin
                acc_lo_r <= mag_b_s;
                mag_b_r  <= mag_a_s;
            end
            if (div0_s) begin
                result_lo_r  <= 16'hFFFF;
                result_hi_r  <= bus.op1;
                regdes_out_r <= bus.regDes_IN;
            end else begin
                result_lo_r  <= result_lo_r;
                result_hi_r  <= result_hi_r;
                regdes_out_r <= regdes_out_r;
            end
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r + 4'd1;
            if (op_r) begin
                acc_hi_r <= div_trial_s[16] ? div_shift_s[15:0] : div_trial_s[15:0];
                acc_lo_r <= {acc_lo_r[14:0], ~div_trial_s[16]};
            end else begin
                acc_hi_r <= mul_sum_s[16:1];
                acc_lo_r <= {mul_sum_s[0], acc_lo_r[15:1]};
            end
        end else if ((state_r == ST_FIX) && !bus.flush) begin
            regdes_out_r <= des_r;
            if (op_r) begin
                result_lo_r <= sign_lo_r ? neg16(acc_lo_r) : acc_lo_r;
                result_hi_r <= sign_hi_r ? neg16(acc_hi_r) : acc_hi_r;
            end else begin
                result_lo_r <= fix_prod_s[15:0];
                result_hi_r <= fix_prod_s[31:16];
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.regWriteOUT = done_r;
    assign bus.R15WriteOUT = done_r;
    assign bus.result_lo   = result_lo_r;
    assign bus.result_hi   = result_hi_r;
    assign bus.regDes_OUT  = regdes_out_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: timing of busy/done, signed results,
// divide by zero, flush, back-to-back issue and asynchronous reset.
module tb_ex_muldiv_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ex_muldiv_unit_if ifc ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the sampling edge N (cycle N+1).
    task automatic start_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] d);
        ifc.start     = 1'b1;
        ifc.op        = o;
        ifc.op1       = a;
        ifc.op2       = b;
        ifc.regDes_IN = d;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // From cycle N+1, check busy over N+1..N+17 and land on cycle N+18.
    // A non-zero pulse_at drives an ignored start (divide by zero) at that RUN cycle.
    task automatic run_window(input string tag, input int pulse_at);
        int bad;
        bad = 0;
        for (int k = 1; k <= 17; k++) begin
            if (!(ifc.busy === 1'b1 && ifc.done === 1'b0)) bad++;
            if (pulse_at != 0 && k == pulse_at) begin
                ifc.start = 1'b1;
                ifc.op    = 1'b1;
                ifc.op1   = 16'h0009;
                ifc.op2   = 16'h0000;
            end
            @(negedge clk);
            ifc.start = 1'b0;
        end
        chk({tag, " busy window"}, 64'(bad), 64'd0);
        chk({tag, " done/busy"}, {62'd0, ifc.done, ifc.busy}, {62'd0, 2'b10});
    endtask

    task automatic chk_result(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                              input logic [3:0] d, input logic dz);
        chk({tag, " result"}, {20'd0, ifc.result_hi, ifc.result_lo, ifc.regDes_OUT, ifc.div_by_zero,
             ifc.regWriteOUT, ifc.R15WriteOUT},
            {20'd0, hi, lo, d, dz, 1'b1, 1'b1});
    endtask

    initial begin
        int bad;
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b0;
        ifc.start     = 1'b0;
        ifc.op        = 1'b0;
        ifc.flush     = 1'b0;
        ifc.op1       = 16'h0000;
        ifc.op2       = 16'h0000;
        ifc.regDes_IN = 4'h0;

        // Reset state
        @(negedge clk);
        chk("reset outputs", {23'd0, ifc.busy, ifc.done, ifc.result_lo, ifc.result_hi, ifc.regDes_OUT,
             ifc.regWriteOUT, ifc.R15WriteOUT, ifc.div_by_zero}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 3 * -2 = -6
        start_op(1'b0, 16'h0003, 16'hFFFE, 4'h5);
        run_window("mul 3x-2", 0);
        chk_result("mul 3x-2", 16'hFFFA, 16'hFFFF, 4'h5, 1'b0);
        @(negedge clk);
        chk("done one cycle", {62'd0, ifc.done, ifc.regWriteOUT}, 64'd0);

        // Divides
        start_op(1'b1, 16'h0007, 16'h0002, 4'h3);
        run_window("div 7/2", 0);
        chk_result("div 7/2", 16'h0003, 16'h0001, 4'h3, 1'b0);
        @(negedge clk);
        start_op(1'b1, 16'hFFF9, 16'h0002, 4'h4);
        run_window("div -7/2", 0);
        chk_result("div -7/2", 16'hFFFD, 16'hFFFF, 4'h4, 1'b0);
        @(negedge clk);
        start_op(1'b1, 16'h8000, 16'hFFFF, 4'h6);
        run_window("div min/-1", 0);
        chk_result("div min/-1", 16'h8000, 16'h0000, 4'h6, 1'b0);
        @(negedge clk);

        // -32768 * -32768
        start_op(1'b0, 16'h8000, 16'h8000, 4'h7);
        run_window("mul min*min", 0);
        chk_result("mul min*min", 16'h0000, 16'h4000, 4'h7, 1'b0);
        @(negedge clk);

        // Divide by zero: done in cycle N+1, no busy
        start_op(1'b1, 16'h1234, 16'h0000, 4'h9);
        chk("div0 done/busy", {62'd0, ifc.done, ifc.busy}, {62'd0, 2'b10});
        chk_result("div0", 16'hFFFF, 16'h1234, 4'h9, 1'b1);
        @(negedge clk);
        chk("div0 after", {62'd0, ifc.done, ifc.busy}, 64'd0);

        // Next accept clears the sticky flag
        start_op(1'b0, 16'h0002, 16'h0003, 4'hA);
        chk("div0 cleared", {63'd0, ifc.div_by_zero}, 64'd0);
        run_window("mul 2x3", 0);
        chk_result("mul 2x3", 16'h0006, 16'h0000, 4'hA, 1'b0);
        @(negedge clk);

        // Flush at RUN iteration 5
        start_op(1'b0, 16'h0011, 16'h0011, 4'h7);
        repeat (5) @(negedge clk);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        chk("flush busy", {63'd0, ifc.busy}, 64'd0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("flush no done", 64'(bad), 64'd0);
        chk("flush kept", {28'd0, ifc.result_hi, ifc.result_lo, ifc.regDes_OUT},
            {28'd0, 16'h0000, 16'h0006, 4'hA});

        // Flush in the DONE cycle: result still commits
        start_op(1'b1, 16'h0064, 16'h0007, 4'h2);
        run_window("div 100/7", 0);
        ifc.flush = 1'b1;
        #1;
        chk_result("div 100/7 flushed done", 16'h000E, 16'h0002, 4'h2, 1'b0);
        @(negedge clk);
        ifc.flush = 1'b0;
        chk("flush done idle", {62'd0, ifc.done, ifc.busy}, 64'd0);

        // Back-to-back: new start in the DONE cycle
        start_op(1'b0, 16'h0005, 16'h0005, 4'h1);
        run_window("mul 5x5", 0);
        chk_result("mul 5x5", 16'h0019, 16'h0000, 4'h1, 1'b0);
        start_op(1'b0, 16'h0100, 16'h0100, 4'hC);
        run_window("b2b mul", 0);
        chk_result("b2b mul", 16'h0000, 16'h0001, 4'hC, 1'b0);
        @(negedge clk);

        // Start pulsed during RUN is ignored
        start_op(1'b0, 16'h0002, 16'h0002, 4'hD);
        run_window("mul ignore start", 4);
        chk_result("mul ignore start", 16'h0004, 16'h0000, 4'hD, 1'b0);
        @(negedge clk);

        // Asynchronous reset at RUN iteration 7
        start_op(1'b0, 16'h0007, 16'h0009, 4'hE);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset mid-run", {23'd0, ifc.busy, ifc.done, ifc.result_lo, ifc.result_hi, ifc.regDes_OUT,
             ifc.regWriteOUT, ifc.R15WriteOUT, ifc.div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_op(1'b0, 16'h0004, 16'hFFFF, 4'h8);
        run_window("mul after reset", 0);
        chk_result("mul after reset", 16'hFFFC, 16'hFFFF, 4'h8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
